// File: rtl/pipelined_carry_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_adder
//
// Pipelined add/subtract unit. A WIDTH-bit operation is cut into STAGES
// ripple-carry segments of SEG = WIDTH/STAGES bits. Each segment owns one
// register stage, so a new operation can enter every cycle. The pipe has a
// single global enable: when the output is held by backpressure, every stage
// freezes together. Bubbles are not collapsed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands valid
//   in_ready   block accepts operands this cycle (= ~out_valid | out_ready)
//   a, b       WIDTH-bit operands
//   cin        carry in for add, ignored for subtract
//   sub        0: a + b + cin, 1: a - b
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        WIDTH-bit result, modulo 2^WIDTH
//   cout       carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        two's-complement signed overflow
// -----------------------------------------------------------------------------
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // Subtraction is a + ~b + 1, so the inversion and the forced carry are
    // applied once at the entry of the pipe.
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             en;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? 1'b1 : cin;

    // Whole-pipe enable. The combinational path from out_ready to in_ready
    // is deliberate: it lets a full pipe accept and deliver in the same cycle.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        // LO: low result bits complete after this stage.
        // REM: operand bits still to be added when entering this stage,
        //      including this stage's own segment.
        localparam int LO  = (gi + 1) * SEG;
        localparam int REM = WIDTH - gi * SEG;

        logic           valid_reg;
        logic           carry_reg;
        logic [LO-1:0]  psum_reg;

        logic           vin;
        logic           cin_s;
        logic [REM-1:0] a_rem;
        logic [REM-1:0] b_rem;
        logic [SEG:0]   seg_res;
        logic [LO-1:0]  psum_next;

        if (gi == 0) begin : g_first
            assign vin       = in_valid;
            assign cin_s     = c0;
            assign a_rem     = a;
            assign b_rem     = b_eff;
            assign psum_next = seg_res[SEG-1:0];
        end else begin : g_next
            assign vin       = g_stage[gi-1].valid_reg;
            assign cin_s     = g_stage[gi-1].carry_reg;
            assign a_rem     = g_stage[gi-1].g_pend.a_up_reg;
            assign b_rem     = g_stage[gi-1].g_pend.b_up_reg;
            // Lower partial sums travel forward unchanged; this segment's
            // result is appended on top.
            assign psum_next = {seg_res[SEG-1:0], g_stage[gi-1].psum_reg};
        end

        // Ripple-carry segment: the lowest SEG not-yet-added bits.
        assign seg_res = {1'b0, a_rem[SEG-1:0]} + {1'b0, b_rem[SEG-1:0]}
                       + {{SEG{1'b0}}, cin_s};

        // Data registers load only on a real operation, so a bubble never
        // disturbs the last delivered result.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                carry_reg <= 1'b0;
                psum_reg  <= '0;
            end else if (en) begin
                valid_reg <= vin;
                if (vin) begin
                    carry_reg <= seg_res[SEG];
                    psum_reg  <= psum_next;
                end
            end
        end

        if (gi < STAGES - 1) begin : g_pend
            // Upper operand bits not yet consumed, handed to the next stage.
            logic [REM-SEG-1:0] a_up_reg;
            logic [REM-SEG-1:0] b_up_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_up_reg <= '0;
                    b_up_reg <= '0;
                end else if (en && vin) begin
                    a_up_reg <= a_rem[REM-1:SEG];
                    b_up_reg <= b_rem[REM-1:SEG];
                end
            end
        end else begin : g_last
            // The top segment still sees the operand MSBs, so signed
            // overflow is resolved here and registered with the sum.
            logic ovf_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_reg <= 1'b0;
                end else if (en && vin) begin
                    ovf_reg <= (a_rem[SEG-1] == b_rem[SEG-1])
                            && (seg_res[SEG-1] != a_rem[SEG-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_reg;
    assign sum       = g_stage[STAGES-1].psum_reg;
    assign cout      = g_stage[STAGES-1].carry_reg;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_reg;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
module tb_pipelined_carry_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
    localparam int LAT    = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              ovf;

    pipelined_carry_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integer arithmetic on the operation's meaning.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mc, input logic ms, input int mcyc);
        exp_t e;
        int   ua, ub, r, sa, sb, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (ms) begin
            r      = ua - ub;
            sr     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            r      = ua + ub + int'(mc);
            sr     = sa + sb + int'(mc);
            e.cout = (r >= 65536);
        end
        e.sum = r[15:0];
        e.ovf = (sr > 32767) || (sr < -32768);
        e.cyc = mcyc;
        return e;
    endfunction

    // Drive one cycle's inputs at the falling edge and sample outputs 1ns later.
    task automatic step(input logic rv, input logic iv, input logic [15:0] ia,
                        input logic [15:0] ib, input logic ic, input logic is,
                        input logic ordy, output logic ov, output logic [15:0] os,
                        output logic oc, output logic oo, output logic ir);
        @(negedge clk);
        rst_n     = rv;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        ov = out_valid;
        os = sum;
        oc = cout;
        oo = ovf;
        ir = in_ready;
    endtask

    task automatic test_reset();
        logic ov, oc, oo, ir;
        logic [15:0] os;
        // rst_n has been low since time 0, so one reset edge has already passed.
        step(1'b0, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, ov, os, oc, oo, ir);
        checks++;
        if (ov !== 1'b0 || os !== 16'h0000 || oc !== 1'b0 || oo !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b sum=%h cout=%b ovf=%b, required 0 0000 0 0", ov, os, oc, oo);
        end
        step(1'b0, 1'b1, 16'h4321, 16'h2222, 1'b1, 1'b0, 1'b1, ov, os, oc, oo, ir);
        checks++;
        if (ov !== 1'b0 || os !== 16'h0000 || oc !== 1'b0 || oo !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: out_valid=%b sum=%h cout=%b ovf=%b, required 0 0000 0 0", ov, os, oc, oo);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, ov, os, oc, oo, ir);
            if (i == 0) begin
                checks++;
                if (ir !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_in_ready: in_ready=%b, required 1", ir);
                end
            end
            checks++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL reset_ghost: out_valid=%b sum=%h, required out_valid=0", ov, os);
            end
        end
        $display("reset: done");
    endtask

    task automatic test_add_sub();
        logic ov, oc, oo, ir, iv;
        logic [15:0] os;
        exp_t e;
        logic [15:0] va[4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0003};
        logic [15:0] vb[4] = '{16'h0001, 16'h0000, 16'h0001, 16'h0005};
        logic        vc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] xs[4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE};
        logic        xc[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        xo[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 14; i++) begin
            iv = (i < 4);
            step(1'b1, iv, va[i%4], vb[i%4], vc[i%4], vs[i%4], 1'b1, ov, os, oc, oo, ir);
            if (ov) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL addsub_extra: out_valid=1 sum=%h, required no result", os);
                end else begin
                    e = exp_q.pop_front();
                    $display("addsub result: sum=%h cout=%b ovf=%b latency=%0d", os, oc, oo, cyc - e.cyc);
                    if (os !== e.sum || oc !== e.cout || oo !== e.ovf || cyc - e.cyc != LAT) begin
                        errors++;
                        $display("FAIL addsub_result: sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                                 os, oc, oo, cyc - e.cyc, e.sum, e.cout, e.ovf, LAT);
                    end
                end
            end
            if (iv) begin
                checks++;
                if (ir !== 1'b1) begin
                    errors++;
                    $display("FAIL addsub_in_ready: in_ready=%b, required 1", ir);
                end else begin
                    exp_q.push_back('{xs[i], xc[i], xo[i], cyc});
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL addsub_missing: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_streaming();
        logic ov, oc, oo, ir, iv, rc, rs;
        logic [15:0] os, ra, rb;
        exp_t e;
        int got = 0;
        for (int i = 0; i < 16; i++) begin
            iv = (i < 8);
            ra = 16'($urandom());
            rb = 16'($urandom());
            rc = 1'($urandom());
            rs = 1'($urandom());
            step(1'b1, iv, ra, rb, rc, rs, 1'b1, ov, os, oc, oo, ir);
            if (ov) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: out_valid=1 sum=%h, required no result", os);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    $display("stream result %0d: sum=%h cout=%b ovf=%b latency=%0d", got, os, oc, oo, cyc - e.cyc);
                    if (os !== e.sum || oc !== e.cout || oo !== e.ovf || cyc - e.cyc != LAT) begin
                        errors++;
                        $display("FAIL stream_result: sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                                 os, oc, oo, cyc - e.cyc, e.sum, e.cout, e.ovf, LAT);
                    end
                end
            end
            if (iv && ir) exp_q.push_back(model(ra, rb, rc, rs, cyc));
        end
        checks++;
        if (got != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got %0d results with %0d outstanding, required 8 and 0", got, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        logic ov, oc, oo, ir, iv, ordy, rc, rs;
        logic [15:0] os, ra, rb, h_sum;
        logic h_cout, h_ovf;
        exp_t e;
        int got = 0;
        int sent = 0;
        h_sum = '0; h_cout = 1'b0; h_ovf = 1'b0;
        for (int i = 0; i < 24; i++) begin
            iv   = (i < 10);
            ordy = !(i >= 4 && i <= 6);
            ra = 16'($urandom());
            rb = 16'($urandom());
            rc = 1'($urandom());
            rs = 1'($urandom());
            step(1'b1, iv, ra, rb, rc, rs, ordy, ov, os, oc, oo, ir);
            if (!ordy) begin
                checks++;
                if (ir !== 1'b0 || ov !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stall: in_ready=%b out_valid=%b, required 0 1", ir, ov);
                end
                if (i == 4) begin
                    h_sum = os; h_cout = oc; h_ovf = oo;
                end else begin
                    checks++;
                    if (os !== h_sum || oc !== h_cout || oo !== h_ovf) begin
                        errors++;
                        $display("FAIL bp_stable: sum=%h cout=%b ovf=%b, required %h %b %b", os, oc, oo, h_sum, h_cout, h_ovf);
                    end
                end
            end
            if (ov && ordy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: out_valid=1 sum=%h, required no result", os);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    $display("backpressure result %0d: sum=%h cout=%b ovf=%b", got, os, oc, oo);
                    if (os !== e.sum || oc !== e.cout || oo !== e.ovf) begin
                        errors++;
                        $display("FAIL bp_result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                                 os, oc, oo, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (iv && ir) begin
                exp_q.push_back(model(ra, rb, rc, rs, cyc));
                sent++;
            end
        end
        checks++;
        if (got != sent || sent != 7 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: sent %0d got %0d outstanding %0d, required 7 7 0", sent, got, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_midreset();
        logic ov, oc, oo, ir, iv, rv, rc, rs;
        logic [15:0] os, ra, rb;
        exp_t e;
        int got = 0;
        for (int i = 0; i < 16; i++) begin
            iv = (i < 3) || (i == 4);
            rv = (i != 3);
            ra = 16'($urandom());
            rb = 16'($urandom());
            rc = 1'($urandom());
            rs = 1'($urandom());
            step(rv, iv, ra, rb, rc, rs, 1'b1, ov, os, oc, oo, ir);
            if (i == 3) exp_q.delete();
            if (i == 4) begin
                checks++;
                if (ir !== 1'b1) begin
                    errors++;
                    $display("FAIL midreset_in_ready: in_ready=%b, required 1", ir);
                end
            end
            if (ov) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL midreset_ghost: out_valid=1 sum=%h at step %0d, required no result", os, i);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    $display("midreset result: sum=%h cout=%b ovf=%b latency=%0d", os, oc, oo, cyc - e.cyc);
                    if (os !== e.sum || oc !== e.cout || oo !== e.ovf || cyc - e.cyc != LAT) begin
                        errors++;
                        $display("FAIL midreset_result: sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                                 os, oc, oo, cyc - e.cyc, e.sum, e.cout, e.ovf, LAT);
                    end
                end
            end
            if (iv && ir && rv) exp_q.push_back(model(ra, rb, rc, rs, cyc));
        end
        checks++;
        if (got != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_count: got %0d results with %0d outstanding, required 1 and 0", got, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_add_sub();
        test_streaming();
        test_backpressure();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
